multi_control_unit_param: RTL and testbench

Parametrised next-generation multi-cycle MIPS-subset control FSM.
- Memory wait states are set by parameters instead of hard-coded wait states. An optional ready handshake can replace them.
- Adds I-type logic/compare ops (andi/ori/slti), a dedicated jr state and an illegal-instruction flag.
- Drives the shared-memory multi-cycle datapath (PC, IR, register file, ALU, muxes) alongside the existing datapath modules.

---
 rtl/multi_control_unit_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multi_control_unit_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_control_unit_param.sv
// Multi-cycle MIPS-subset control FSM with parameterised memory wait states.
// Define MEM_READY_EN to replace the fixed wait states with a mem_ready handshake.
module multi_control_unit_param #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned STORE_LAT = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
`ifdef MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       ToggleEqual,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZext,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       illegal,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_MEMADR = 5'd2,
        S_MEMRD  = 5'd3,
        S_MEMWB  = 5'd4,
        S_MEMWR  = 5'd5,
        S_EXEC   = 5'd6,
        S_ALUWB  = 5'd7,
        S_BEQ    = 5'd8,
        S_BNE    = 5'd9,
        S_IEXEC  = 5'd10,
        S_IWB    = 5'd11,
        S_JUMP   = 5'd12,
        S_JAL    = 5'd13,
        S_JR     = 5'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_illegal;
    logic       w_set_illegal;
    logic [3:0] w_lat;
    logic       w_at_lat;
    logic       w_fetch_done;
    logic       w_load_done;
    logic       w_store_done;
    logic [2:0] w_r_alu;
    logic       w_r_valid;
    logic [2:0] w_i_alu;
    logic       w_i_zext;

    // The counter saturates at the current state's latency in both builds.
    always_comb begin
        w_lat = 4'd0;
        case (r_state)
            S_FETCH: w_lat = 4'(FETCH_LAT);
            S_MEMRD: w_lat = 4'(LOAD_LAT);
            S_MEMWR: w_lat = 4'(STORE_LAT);
            default: w_lat = 4'd0;
        endcase
    end

    assign w_at_lat = (r_cnt == w_lat);

`ifdef MEM_READY_EN
    assign w_fetch_done = mem_ready;
    assign w_load_done  = mem_ready;
    assign w_store_done = mem_ready;
`else
    assign w_fetch_done = w_at_lat;
    assign w_load_done  = w_at_lat;
    assign w_store_done = w_at_lat;
`endif

    always_comb begin
        w_r_alu   = ALU_AND;
        w_r_valid = 1'b1;
        case (Funct)
            6'b100000: w_r_alu = ALU_ADD;
            6'b100010: w_r_alu = ALU_SUB;
            6'b100100: w_r_alu = ALU_AND;
            6'b100101: w_r_alu = ALU_OR;
            6'b101010: w_r_alu = ALU_SLT;
            default:   w_r_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_i_alu  = ALU_ADD;
        w_i_zext = 1'b0;
        case (Op)
            OP_ANDI: begin w_i_alu = ALU_AND; w_i_zext = 1'b1; end
            OP_ORI:  begin w_i_alu = ALU_OR;  w_i_zext = 1'b1; end
            OP_SLTI: w_i_alu = ALU_SLT;
            default: w_i_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = w_fetch_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = (Funct == FN_JR) ? S_JR : S_EXEC;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_BNE:       w_next = S_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEXEC;
                    OP_J:         w_next = S_JUMP;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next        = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = w_load_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_store_done ? S_FETCH : S_MEMWR;
            S_EXEC: begin
                w_next        = w_r_valid ? S_ALUWB : S_FETCH;
                w_set_illegal = ~w_r_valid;
            end
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_FETCH;
            r_cnt     <= 4'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= 4'd0;
            else if (!w_at_lat)
                r_cnt <= r_cnt + 4'd1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    // Moore decode; every strobe defaults to 0 outside the states that use it.
    always_comb begin
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        ToggleEqual = 1'b0;
        PCSrc       = 2'b00;
        ALUControl  = 3'b000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ImmZext     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = w_fetch_done;
                PCWrite    = w_fetch_done;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_r_alu;
            end
            S_ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                Branch      = 1'b1;
                PCSrc       = 2'b01;
                ToggleEqual = (r_state == S_BNE);
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = w_i_alu;
                ImmZext    = w_i_zext;
            end
            S_IWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            S_JAL: begin
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                ALUSrcA = 1'b1;
                PCSrc   = 2'b11;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign state   = r_state;

endmodule

// File: tb/tb_multi_control_unit_param.sv
// Scoreboard bench for multi_control_unit_param: per-cycle expected control
// vectors are queued per instruction, then compared cycle by cycle.
module tb_multi_control_unit_param;

    localparam int FETCH_LAT = 1;
    localparam int LOAD_LAT  = 2;
    localparam int STORE_LAT = 0;
`ifdef MEM_READY_EN
    localparam int FL_N = 2;
    localparam int LL_N = 1;
    localparam int SL_N = 0;
`else
    localparam int FL_N = FETCH_LAT;
    localparam int LL_N = LOAD_LAT;
    localparam int SL_N = STORE_LAT;
`endif

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] AND = 3'b000;
    localparam logic [2:0] OR  = 3'b001;
    localparam logic [2:0] SLT = 3'b111;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op;
    logic [5:0] Funct;
`ifdef MEM_READY_EN
    logic       mem_ready;
`endif
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ImmZext, RegWrite;
    logic [1:0] RegDst, MemtoReg;
    logic       illegal;
    logic [4:0] state;

    multi_control_unit_param #(
        .FETCH_LAT(FETCH_LAT), .LOAD_LAT(LOAD_LAT), .STORE_LAT(STORE_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct),
`ifdef MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .ToggleEqual(ToggleEqual), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmZext(ImmZext), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [25:0] dut_v;
    assign dut_v = {state, IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual,
                    PCSrc, ALUControl, ALUSrcA, ALUSrcB, ImmZext, RegWrite,
                    RegDst, MemtoReg, illegal};

    typedef struct packed {
        logic        rdy;
        logic [25:0] v;
    } rec_t;

    rec_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  exp_ill = 1'b0;
    string tag = "reset";

    function automatic logic [25:0] mk(
        input logic [4:0] st, input logic iord, input logic mw, input logic irw,
        input logic pcw, input logic br, input logic te, input logic [1:0] pcsrc,
        input logic [2:0] alu, input logic srca, input logic [1:0] srcb,
        input logic zext, input logic rw, input logic [1:0] rdst, input logic [1:0] m2r);
        return {st, iord, mw, irw, pcw, br, te, pcsrc, alu, srca, srcb, zext, rw,
                rdst, m2r, exp_ill};
    endfunction

    task automatic push(input logic rdy, input logic [25:0] v);
        rec_t r;
        r.rdy = rdy;
        r.v   = v;
        q.push_back(r);
    endtask

    task automatic check(input logic [25:0] exp_v);
        n_tests++;
        assert (dut_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, dut_v, exp_v);
        end
    endtask

    task automatic run_n(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = q.pop_front();
`ifdef MEM_READY_EN
            mem_ready = r.rdy;
`endif
            #1;
            check(r.v);
            @(negedge clk);
        end
    endtask

    task automatic run_q(input string t);
        tag = t;
        run_n(q.size());
    endtask

    task automatic p_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push(1'b0, mk(5'd0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        push(1'b1, mk(5'd0, 0, 0, 1, 1, 0, 0, 2'b00, ADD, 0, 2'b01, 0, 0, 2'b00, 2'b00));
    endtask

    task automatic p_decode(input logic [5:0] op, input logic [5:0] fn);
        Op    = op;
        Funct = fn;
        p_fetch(FL_N);
        // mem_ready high during DECODE must be ignored
        push(1'b1, mk(5'd1, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b11, 0, 0, 2'b00, 2'b00));
    endtask

    task automatic r_type(input logic [5:0] fn, input logic [2:0] alu, input string t);
        p_decode(6'b000000, fn);
        push(1'b0, mk(5'd6, 0, 0, 0, 0, 0, 0, 2'b00, alu, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        push(1'b0, mk(5'd7, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 1, 2'b01, 2'b00));
        run_q(t);
    endtask

    task automatic i_type(input logic [5:0] op, input logic [2:0] alu, input logic zext,
                          input string t);
        p_decode(op, 6'b010101);
        push(1'b0, mk(5'd10, 0, 0, 0, 0, 0, 0, 2'b00, alu, 1, 2'b10, zext, 0, 2'b00, 2'b00));
        push(1'b0, mk(5'd11, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 1, 2'b00, 2'b00));
        run_q(t);
    endtask

    task automatic push_lw();
        p_decode(6'b100011, 6'b000000);
        push(1'b0, mk(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 2'b10, 0, 0, 2'b00, 2'b00));
        for (int i = 0; i < LL_N; i++)
            push(1'b0, mk(5'd3, 1, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        push(1'b1, mk(5'd3, 1, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        push(1'b0, mk(5'd4, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 1, 2'b00, 2'b01));
    endtask

    task automatic reset_pulse(input string t);
        tag = t;
        rstn = 1'b0;
        exp_ill = 1'b0;
        #1;
        check(mk(5'd0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn  = 1'b0;
        Op    = 6'b000000;
        Funct = 6'b000000;
`ifdef MEM_READY_EN
        mem_ready = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check(mk(5'd0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b01, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        rstn = 1'b1;

        r_type(6'b100000, ADD, "add");
        r_type(6'b100010, SUB, "sub");
        r_type(6'b100100, AND, "and");
        r_type(6'b100101, OR,  "or");
        r_type(6'b101010, SLT, "slt");

        push_lw();
        run_q("lw");

        p_decode(6'b101011, 6'b000000);
        push(1'b0, mk(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 2'b10, 0, 0, 2'b00, 2'b00));
        for (int i = 0; i < SL_N; i++)
            push(1'b0, mk(5'd5, 1, 1, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        push(1'b1, mk(5'd5, 1, 1, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        run_q("sw");

        p_decode(6'b000100, 6'b000000);
        push(1'b0, mk(5'd8, 0, 0, 0, 0, 1, 0, 2'b01, SUB, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        run_q("beq");

        p_decode(6'b000101, 6'b000000);
        push(1'b0, mk(5'd9, 0, 0, 0, 0, 1, 1, 2'b01, SUB, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        run_q("bne");

        i_type(6'b001000, ADD, 1'b0, "addi");
        i_type(6'b001100, AND, 1'b1, "andi");
        i_type(6'b001101, OR,  1'b1, "ori");
        i_type(6'b001010, SLT, 1'b0, "slti");

        p_decode(6'b000010, 6'b000000);
        push(1'b0, mk(5'd12, 0, 0, 0, 1, 0, 0, 2'b10, AND, 0, 2'b00, 0, 0, 2'b00, 2'b00));
        run_q("j");

        p_decode(6'b000011, 6'b000000);
        push(1'b0, mk(5'd13, 0, 0, 0, 1, 0, 0, 2'b10, AND, 0, 2'b00, 0, 1, 2'b10, 2'b10));
        run_q("jal");

        p_decode(6'b000000, 6'b001000);
        push(1'b0, mk(5'd14, 0, 0, 0, 1, 0, 0, 2'b11, AND, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        run_q("jr");

        // Illegal opcode: back to FETCH with the sticky flag raised
        p_decode(6'b111111, 6'b000000);
        exp_ill = 1'b1;
        run_q("illegal_op");
        r_type(6'b100000, ADD, "add_after_illegal");
        reset_pulse("illegal_clear");

        p_decode(6'b000000, 6'b111111);
        push(1'b0, mk(5'd6, 0, 0, 0, 0, 0, 0, 2'b00, AND, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        exp_ill = 1'b1;
        run_q("illegal_funct");
        i_type(6'b001101, OR, 1'b1, "ori_after_illegal");

        // Reset in the middle of a load, then confirm FETCH restarts its count
        reset_pulse("clear_before_lw");
        push_lw();
        tag = "lw_partial";
        run_n(FL_N + 4);
        q.delete();
        reset_pulse("reset_mid_memrd");
        r_type(6'b100010, SUB, "sub_after_reset");

`ifdef MEM_READY_EN
        p_fetch(4);
        push(1'b0, mk(5'd1, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b11, 0, 0, 2'b00, 2'b00));
        Op    = 6'b000000;
        Funct = 6'b100000;
        push(1'b1, mk(5'd6, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 2'b00, 0, 0, 2'b00, 2'b00));
        push(1'b0, mk(5'd7, 0, 0, 0, 0, 0, 0, 2'b00, AND, 0, 2'b00, 0, 1, 2'b01, 2'b00));
        run_q("ready_fetch_5");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
